// File: rtl/hedios_tx_arbiter.sv
// Round-robin scheduler sharing the Hedios UART endpoint's single packet-transmit path.
// Optional sender watchdog is compiled in by defining HEDIOS_TX_TIMEOUT_EN.
module hedios_tx_arbiter #(
  parameter int REQ_COUNT      = 4,
  parameter int DATA_WIDTH     = 40,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [REQ_COUNT-1:0]            req_valid,
  input  logic [REQ_COUNT*DATA_WIDTH-1:0] req_data,
  output logic [REQ_COUNT-1:0]            req_ready,
  output logic                            tx_valid,
  output logic [DATA_WIDTH-1:0]           tx_data,
  input  logic                            tx_ready,
  input  logic                            tx_done,
  output logic                            busy,
  output logic [$clog2(REQ_COUNT)-1:0]    grant_id,
  output logic                            timeout_err
);
  // state     | meaning
  // IDLE      | no packet held; arbitrate among req_valid
  // OFFER     | tx_valid high, waiting for the sender to take tx_data
  // WAIT_DONE | packet accepted, waiting for tx_done

  localparam int IDX_W = $clog2(REQ_COUNT);

  typedef enum logic [1:0] {ST_IDLE, ST_OFFER, ST_WAIT_DONE} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       last_grant, last_grant_nxt;
  logic [REQ_COUNT-1:0]   req_ready_nxt;
  logic                   tx_valid_nxt;
  logic [DATA_WIDTH-1:0]  tx_data_nxt;
  logic                   busy_nxt;
  logic [IDX_W-1:0]       grant_id_nxt;
  logic                   timeout_err_nxt;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       cand;
  logic                   done_now;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % REQ_COUNT;
    return IDX_W'(s);
  endfunction

  // Scan offsets high to low so the nearest set bit after last_grant wins.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    for (int off = REQ_COUNT; off >= 1; off--) begin
      cand = wrap_idx(last_grant, off);
      if (req_valid[cand]) win_idx = cand;
    end
  end

  assign done_now = ((state == ST_OFFER) && tx_ready && tx_done) ||
                    ((state == ST_WAIT_DONE) && tx_done);

`ifdef HEDIOS_TX_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_cnt, tmo_cnt_nxt;
  always_comb begin
    tmo_cnt_nxt = (state == ST_IDLE) ? '0 : tmo_cnt + 32'd1;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    req_ready_nxt   = '0;
    tx_valid_nxt    = tx_valid;
    tx_data_nxt     = tx_data;
    busy_nxt        = busy;
    grant_id_nxt    = grant_id;
    timeout_err_nxt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (|req_valid) begin
          state_nxt              = ST_OFFER;
          tx_data_nxt            = req_data[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          grant_id_nxt           = win_idx;
          req_ready_nxt[win_idx] = 1'b1;
          tx_valid_nxt           = 1'b1;
          busy_nxt               = 1'b1;
        end
      end
      ST_OFFER: begin
        if (tx_ready) begin
          tx_valid_nxt = 1'b0;
          state_nxt    = tx_done ? ST_IDLE : ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: tx_valid_nxt = 1'b0;
      default:      state_nxt    = ST_IDLE;
    endcase
    if (done_now) begin
      state_nxt      = ST_IDLE;
      busy_nxt       = 1'b0;
      last_grant_nxt = grant_id;
    end
`ifdef HEDIOS_TX_TIMEOUT_EN
    // Abort advances the pointer too, so a stuck sender cannot starve others.
    else if ((state != ST_IDLE) && (tmo_cnt == TMO_LAST)) begin
      state_nxt       = ST_IDLE;
      tx_valid_nxt    = 1'b0;
      busy_nxt        = 1'b0;
      timeout_err_nxt = 1'b1;
      last_grant_nxt  = grant_id;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= IDX_W'(REQ_COUNT - 1);
      req_ready   <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
`ifdef HEDIOS_TX_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      req_ready   <= req_ready_nxt;
      tx_valid    <= tx_valid_nxt;
      tx_data     <= tx_data_nxt;
      busy        <= busy_nxt;
      grant_id    <= grant_id_nxt;
      timeout_err <= timeout_err_nxt;
`ifdef HEDIOS_TX_TIMEOUT_EN
      tmo_cnt     <= tmo_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_hedios_tx_arbiter.sv
// Randomized scoreboard bench for hedios_tx_arbiter (4 requesters, 40-bit packets).
module tb_hedios_tx_arbiter;
  localparam int N = 4;
  localparam int W = 40;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [W-1:0]   tx_data;
  logic           tx_ready;
  logic           tx_done;
  logic           busy;
  logic [1:0]     grant_id;
  logic           timeout_err;

  hedios_tx_arbiter #(.REQ_COUNT(N), .DATA_WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_done(tx_done), .busy(busy), .grant_id(grant_id),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] ready;
    logic [1:0]   id;
    logic [W-1:0] data;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_vec = 0;
  int           n_bad = 0;
  bit           tmo_ok = 1'b0;
  logic [N-1:0] vmask;
  logic [W-1:0] pkt[N];
  int           ptr;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [W-1:0] rand_pkt();
    return {8'($urandom), 32'($urandom)};
  endfunction

  // Reference arbitration: first pending requester after the last completed one.
  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 1; k <= N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic drive_inputs();
    req_valid = vmask;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = pkt[i];
  endtask

  task automatic apply(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) if (mask[i] && !vmask[i]) pkt[i] = rand_pkt();
    vmask = mask;
    drive_inputs();
  endtask

  always @(negedge clk) begin
    if (rst_n && req_ready != '0) begin
      if (sb.size() == 0) check("unexpected_grant", 64'(req_ready), 64'd0);
      else begin
        mon_e = sb.pop_front();
        check("grant_ready", 64'(req_ready), 64'(mon_e.ready));
        check("grant_id", 64'(grant_id), 64'(mon_e.id));
        check("grant_data", 64'(tx_data), 64'(mon_e.data));
        check("grant_valid_busy", {62'd0, tx_valid, busy}, 64'd3);
      end
    end
    if (timeout_err && !tmo_ok) check("spurious_timeout", 64'(timeout_err), 64'd0);
  end

  task automatic run_round(input logic [N-1:0] mask, input int offer_dly, input bit same_cycle,
                           input int wait_dly, input bit reset_mid, input bit hang);
    int w, lat, j;
    logic [W-1:0] gdata;
    apply(mask);
    w = pick(vmask, ptr);
    gdata = pkt[w];
    sb.push_back('{ready: N'(1 << w), id: 2'(w), data: gdata});
    lat = 0;
    do begin @(negedge clk); lat++; end while (req_ready == '0 && lat < 20);
    if (req_ready == '0) begin
      check("grant_seen", 64'd0, 64'd1);
      sb.delete();
      return;
    end
    check("grant_latency", 64'(lat), 64'd1);
    vmask[w] = 1'($urandom_range(0, 1));
    if (vmask[w]) pkt[w] = rand_pkt();
    drive_inputs();
    if (hang) begin
      tmo_ok = 1'b1;
      for (int i = 1; i <= 16; i++) begin
        @(negedge clk);
        if (i < 16) check("tmo_hold", {62'd0, tx_valid, timeout_err}, 64'd2);
        else check("tmo_abort", {61'd0, tx_valid, busy, timeout_err}, 64'd1);
      end
      apply('0);
      @(negedge clk);
      check("tmo_single_pulse", {59'd0, timeout_err, req_ready}, 64'd0);
      tmo_ok = 1'b0;
      ptr = w;
      return;
    end
    for (int i = 0; i < offer_dly; i++) begin
      tx_done = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        j = int'($urandom_range(0, N - 1));
        if (!vmask[j]) begin vmask[j] = 1'b1; pkt[j] = rand_pkt(); drive_inputs(); end
      end
      @(negedge clk);
      check("offer_hold", {22'd0, tx_valid, busy, tx_data}, {22'd0, 2'b11, gdata});
    end
    tx_ready = 1'b1;
    tx_done  = same_cycle;
    @(negedge clk);
    tx_ready = 1'b0;
    tx_done  = 1'b0;
    if (same_cycle) begin
      check("same_cycle_idle", {62'd0, tx_valid, busy}, 64'd0);
      ptr = w;
      return;
    end
    check("accept_hold", {22'd0, tx_valid, busy, tx_data}, {22'd0, 2'b01, gdata});
    for (int i = 0; i < wait_dly; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("wait_hold", {22'd0, tx_valid, busy, tx_data}, {22'd0, 2'b01, gdata});
    end
    tx_ready = 1'b0;
    if (reset_mid) begin
      rst_n = 1'b0;
      @(negedge clk);
      check("reset_mid_clear", {15'd0, req_ready, tx_valid, tx_data, busy, grant_id, timeout_err}, 64'd0);
      rst_n = 1'b1;
      ptr = N - 1;
      return;
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("done_idle", {60'd0, tx_valid, busy, grant_id}, {60'd0, 2'b00, 2'(w)});
    ptr = w;
  endtask

  initial begin
    logic [N-1:0] m;
    int od;
    rst_n    = 1'b0;
    tx_ready = 1'b0;
    tx_done  = 1'b0;
    vmask    = '0;
    for (int i = 0; i < N; i++) pkt[i] = '0;
    drive_inputs();
    ptr = N - 1;
    repeat (3) @(negedge clk);
    check("reset_state", {15'd0, req_ready, tx_valid, tx_data, busy, grant_id, timeout_err}, 64'd0);
    rst_n = 1'b1;

    vmask[2] = 1'b1;
    pkt[2]   = 40'h05_DEADBEEF;
    drive_inputs();
    run_round(4'b0100, 1, 1'b0, 2, 1'b0, 1'b0);
    run_round(4'b1111, 0, 1'b0, 1, 1'b1, 1'b0);
    repeat (6) run_round(4'b1111, 0, 1'b1, 0, 1'b0, 1'b0);
    run_round(4'b0011, 50, 1'b0, 3, 1'b0, 1'b0);
`ifdef HEDIOS_TX_TIMEOUT_EN
    run_round(4'b1111, 0, 1'b0, 0, 1'b0, 1'b1);
    run_round(4'b1111, 0, 1'b1, 0, 1'b0, 1'b0);
`endif
    repeat (60) begin
      m = N'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) m = m | vmask;
      od = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(0, 3));
      run_round(m, od, $urandom_range(0, 2) == 0, int'($urandom_range(0, 4)), 1'b0, 1'b0);
    end
    apply('0);
    repeat (3) @(negedge clk);
    if (sb.size() != 0) check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
